// File: rtl/hash_search_ctrl_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : hash_search_ctrl_pkg
// Description : Shared widths, reset values, state encodings and the hash
//               validation rule for the micro-ucr-hash search sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package hash_search_ctrl_pkg;

    localparam int NONCE_W       = 32;
    localparam int HASH_W        = 24;
    localparam int DEF_PAYLOAD_W = 96;

    localparam logic [HASH_W-1:0] HASH_RESET = 24'hffffff;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // A hash is a hit when both upper bytes are strictly below the target.
    // A zero target can therefore never hit.
    function automatic logic hash_hit(input logic [HASH_W-1:0] hash,
                                      input logic [7:0]        target);
        return (hash[23:16] < target) && (hash[15:8] < target);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hash_search_ctrl_tag_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : nonce_tag_pipe
// Description : DEPTH-stage shift of {valid, nonce} that follows each bloque
//               through the hash core so the returning hash can be matched
//               to the nonce that produced it.
// Revision    : 1.0 - initial release
// ============================================================================
module nonce_tag_pipe
    import hash_search_ctrl_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [NONCE_W-1:0] in_nonce,
    output logic               out_valid,
    output logic [NONCE_W-1:0] out_nonce
);

    logic [DEPTH-1:0]   valid_q;
    logic [NONCE_W-1:0] nonce_q [DEPTH];

    // Valid bits shift one stage per cycle; flush discards everything in flight
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Nonces ride alongside the valid bits; only meaningful where valid is set
    always_ff @(posedge clk) begin
        nonce_q[0] <= in_nonce;
        for (int i = 1; i < DEPTH; i++) begin
            nonce_q[i] <= nonce_q[i-1];
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_nonce = nonce_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/hash_search_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : hash_search_ctrl
// Description : Nonce-range sequencer for the micro-ucr-hash core. Issues one
//               {payload, nonce} bloque per cycle, validates returned hashes,
//               stops on first hit or range end and holds the result until ack.
// Revision    : 1.0 - initial release
// ============================================================================
module hash_search_ctrl
    import hash_search_ctrl_pkg::*;
#(
    parameter int HASH_LATENCY = 1,
    parameter int PAYLOAD_W    = DEF_PAYLOAD_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         ack,
    input  logic [PAYLOAD_W-1:0]         payload_in,
    input  logic [7:0]                   target_in,
    input  logic [NONCE_W-1:0]           nonce_start,
    input  logic [NONCE_W-1:0]           nonce_limit,
    output logic                         core_active,
    output logic [PAYLOAD_W+NONCE_W-1:0] core_bloque,
    input  logic [HASH_W-1:0]            core_hash,
    output logic                         busy,
    output logic                         done,
    output logic                         found,
    output logic [NONCE_W-1:0]           nonce_out,
    output logic [HASH_W-1:0]            hash_out,
    output logic [31:0]                  attempts
);

    logic [1:0]           state;
    logic [PAYLOAD_W-1:0] payload_q;
    logic [7:0]           target_q;
    logic [NONCE_W-1:0]   limit_q;
    logic [NONCE_W-1:0]   issue_nonce;   // nonce currently on core_bloque
    logic                 issue_valid;   // core_bloque carries a live nonce

    logic                 exit_valid;
    logic [NONCE_W-1:0]   exit_nonce;

    logic accept;
    logic in_flight;
    logic hit;
    logic last_exit;
    logic flush;

    assign accept    = (state == ST_IDLE) && start && !abort;
    assign in_flight = (state == ST_RUN) || (state == ST_DRAIN);
    assign hit       = in_flight && exit_valid && hash_hit(core_hash, target_q);
    // Range end is detected by equality, so the final tag is unique even when
    // the range wraps through 32'hffffffff or spans all 2^32 nonces.
    assign last_exit = in_flight && exit_valid && (exit_nonce == limit_q);
    assign flush     = abort || hit;

    assign core_bloque = {payload_q, issue_nonce};
    assign core_active = in_flight;
    assign busy        = in_flight;
    assign done        = (state == ST_DONE);

    nonce_tag_pipe #(
        .DEPTH     (HASH_LATENCY)
    ) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (issue_valid),
        .in_nonce  (issue_nonce),
        .out_valid (exit_valid),
        .out_nonce (exit_nonce)
    );

    // Search FSM, input latches, nonce issue and result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            payload_q   <= '0;
            target_q    <= '0;
            limit_q     <= '0;
            issue_nonce <= '0;
            issue_valid <= 1'b0;
            found       <= 1'b0;
            nonce_out   <= '0;
            hash_out    <= HASH_RESET;
        end else if (abort) begin
            if (state != ST_IDLE) begin
                state       <= ST_IDLE;
                issue_valid <= 1'b0;
                found       <= 1'b0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_RUN;
                        payload_q   <= payload_in;
                        target_q    <= target_in;
                        limit_q     <= nonce_limit;
                        issue_nonce <= nonce_start;
                        issue_valid <= 1'b1;
                        found       <= 1'b0;
                        nonce_out   <= '0;
                        hash_out    <= HASH_RESET;
                    end
                end
                ST_RUN: begin
                    if (hit) begin
                        // A hit outranks range end issued on the same cycle
                        state       <= ST_DONE;
                        issue_valid <= 1'b0;
                        found       <= 1'b1;
                        nonce_out   <= exit_nonce;
                        hash_out    <= core_hash;
                    end else if (issue_nonce == limit_q) begin
                        state       <= ST_DRAIN;
                        issue_valid <= 1'b0;
                    end else begin
                        issue_nonce <= issue_nonce + 32'd1;
                    end
                end
                ST_DRAIN: begin
                    if (hit) begin
                        state     <= ST_DONE;
                        found     <= 1'b1;
                        nonce_out <= exit_nonce;
                        hash_out  <= core_hash;
                    end else if (last_exit) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (ack) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating count of hashes checked; held across abort
    always_ff @(posedge clk) begin
        if (reset) begin
            attempts <= '0;
        end else if (accept) begin
            attempts <= '0;
        end else if (!abort && in_flight && exit_valid && (attempts != 32'hffffffff)) begin
            attempts <= attempts + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hash_search_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_hash_search_ctrl
// Description : Scoreboard bench for hash_search_ctrl with scripted hash-core
//               stubs at latency 1 and latency 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hash_search_ctrl;

    typedef struct packed {
        logic        found;
        logic [31:0] nonce;
        logic [23:0] hash;
        logic [31:0] attempts;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        start = 1'b0, start3 = 1'b0, abort = 1'b0, ack = 1'b0, ack3 = 1'b0;
    logic [95:0] payload = '0;
    logic [7:0]  target = '0;
    logic [31:0] n_start = '0, n_limit = '0;

    logic         act1, busy1, done1, found1;
    logic [127:0] bloque1;
    logic [23:0]  hash1 = '0, hout1;
    logic [31:0]  nout1, att1;

    logic         act3, busy3, done3, found3;
    logic [127:0] bloque3;
    logic [23:0]  h3a = '0, h3b = '0, hash3 = '0, hout3;
    logic [31:0]  nout3, att3;

    // scripted core behaviour: one nonce returns m_hash, all others a non-hit
    logic        m_en = 1'b0;
    logic [31:0] m_nonce = '0;
    logic [23:0] m_hash = '0;

    exp_t        exp_q[$];
    logic [31:0] seen[$];
    int          n_checks = 0;
    int          n_pass = 0;

    hash_search_ctrl #(.HASH_LATENCY(1), .PAYLOAD_W(96)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .ack(ack),
        .payload_in(payload), .target_in(target),
        .nonce_start(n_start), .nonce_limit(n_limit),
        .core_active(act1), .core_bloque(bloque1), .core_hash(hash1),
        .busy(busy1), .done(done1), .found(found1),
        .nonce_out(nout1), .hash_out(hout1), .attempts(att1)
    );

    hash_search_ctrl #(.HASH_LATENCY(3), .PAYLOAD_W(96)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .abort(abort), .ack(ack3),
        .payload_in(payload), .target_in(target),
        .nonce_start(n_start), .nonce_limit(n_limit),
        .core_active(act3), .core_bloque(bloque3), .core_hash(hash3),
        .busy(busy3), .done(done3), .found(found3),
        .nonce_out(nout3), .hash_out(hout3), .attempts(att3)
    );

    function automatic logic [23:0] hash_of(input logic [31:0] n);
        return (m_en && n == m_nonce) ? m_hash : 24'hFFFF00;
    endfunction

    // hash core stubs
    always @(posedge clk) hash1 <= hash_of(bloque1[31:0]);
    always @(posedge clk) begin
        h3a   <= hash_of(bloque3[31:0]);
        h3b   <= h3a;
        hash3 <= h3b;
    end

    // record each distinct bloque nonce presented by the latency-1 DUT
    always @(negedge clk) begin
        if (act1 && (seen.size() == 0 || seen[seen.size()-1] != bloque1[31:0]))
            seen.push_back(bloque1[31:0]);
    end

    // reference search: walk the range in order, first hit wins
    function automatic exp_t model(input logic [31:0] s, input logic [31:0] l,
                                   input logic [7:0] t);
        exp_t        e;
        logic [31:0] n;
        logic [23:0] h;
        e.found = 1'b0; e.nonce = '0; e.hash = 24'hFFFFFF; e.attempts = '0;
        n = s;
        for (int k = 0; k < 70000; k++) begin
            h = hash_of(n);
            e.attempts = e.attempts + 1;
            if (h[23:16] < t && h[15:8] < t) begin
                e.found = 1'b1; e.nonce = n; e.hash = h;
                return e;
            end
            if (n == l) return e;
            n = n + 1;
        end
        return e;
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [31:0] s, input logic [31:0] l, input logic [7:0] t,
                          input bit use3, input bit push);
        n_start = s; n_limit = l; target = t;
        payload = {$urandom, $urandom, $urandom};
        if (push) exp_q.push_back(model(s, l, t));
        if (use3) start3 = 1'b1; else start = 1'b1;
        tick();
        start = 1'b0; start3 = 1'b0;
    endtask

    task automatic wait_done(input bit use3, input int budget);
        int k = 0;
        while (!(use3 ? done3 : done1) && k < budget) begin
            tick();
            k++;
        end
        check_eq("done_reached", use3 ? done3 : done1, 1'b1);
    endtask

    task automatic compare_result(input bit use3);
        exp_t e;
        check_eq("sb_nonempty", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("found",    use3 ? found3 : found1, e.found);
            check_eq("nonce",    use3 ? nout3 : nout1,   e.nonce);
            check_eq("hash",     use3 ? hout3 : hout1,   e.hash);
            check_eq("attempts", use3 ? att3 : att1,     e.attempts);
        end
    endtask

    task automatic release_done(input bit use3);
        if (use3) ack3 = 1'b1; else ack = 1'b1;
        tick();
        ack = 1'b0; ack3 = 1'b0;
        check_eq("ack_release", use3 ? done3 : done1, 1'b0);
        check_eq("ack_idle",    use3 ? busy3 : busy1, 1'b0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        // reset state, reset still asserted
        check_eq("rst_busy",   busy1,   1'b0);
        check_eq("rst_done",   done1,   1'b0);
        check_eq("rst_active", act1,    1'b0);
        check_eq("rst_bloque", bloque1, 128'h0);
        check_eq("rst_hash",   hout1,   24'hFFFFFF);
        check_eq("rst_nonce",  nout1,   32'h0);
        check_eq("rst_att",    att1,    32'h0);
        check_eq("rst_found",  found1,  1'b0);
        reset = 1'b0;
        tick();

        // 1: hit inside the range
        seen.delete();
        m_en = 1'b1; m_nonce = 32'h150; m_hash = 24'h0A05FF;
        launch(32'h100, 32'h1FF, 8'h10, 1'b0, 1'b1);
        check_eq("t1_bloque0", bloque1, {payload, 32'h100});
        check_eq("t1_active",  act1,    1'b1);
        wait_done(1'b0, 1000);
        compare_result(1'b0);
        check_eq("t1_nbloques", seen.size(), 32'h52);
        check_eq("t1_lastbloque", seen[seen.size()-1], 32'h151);
        release_done(1'b0);

        // 2: full range, no hit
        m_en = 1'b0;
        launch(32'h100, 32'h1FF, 8'h10, 1'b0, 1'b1);
        wait_done(1'b0, 1000);
        compare_result(1'b0);
        release_done(1'b0);

        // 3: range wraps through ffffffff
        seen.delete();
        launch(32'hFFFFFFFE, 32'h1, 8'h10, 1'b0, 1'b1);
        wait_done(1'b0, 100);
        compare_result(1'b0);
        check_eq("t3_nbloques", seen.size(), 32'd4);
        if (seen.size() == 4) begin
            check_eq("t3_b0", seen[0], 32'hFFFFFFFE);
            check_eq("t3_b1", seen[1], 32'hFFFFFFFF);
            check_eq("t3_b2", seen[2], 32'h0);
            check_eq("t3_b3", seen[3], 32'h1);
        end
        release_done(1'b0);

        // 4: hit on the single nonce start == limit
        m_en = 1'b1; m_nonce = 32'h7; m_hash = 24'h0A05FF;
        launch(32'h7, 32'h7, 8'h10, 1'b0, 1'b1);
        wait_done(1'b0, 100);
        compare_result(1'b0);
        release_done(1'b0);

        // 5: abort three cycles into RUN; the later hit must not surface
        m_nonce = 32'h305;
        launch(32'h300, 32'h3FF, 8'h10, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("t5_busy",   busy1,  1'b0);
        check_eq("t5_active", act1,   1'b0);
        check_eq("t5_found",  found1, 1'b0);
        check_eq("t5_att",    att1,   32'd1);
        repeat (20) tick();
        check_eq("t5_nodone", done1,  1'b0);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check_eq("t5_abort_wins", busy1, 1'b0);

        // 6a: start/ack while busy ignored, start in DONE ignored
        m_nonce = 32'h180;
        launch(32'h100, 32'h1FF, 8'h05, 1'b0, 1'b1);
        repeat (5) tick();
        n_start = 32'h0; n_limit = 32'h0; target = 8'hFF;
        start = 1'b1; ack = 1'b1;
        tick();
        start = 1'b0; ack = 1'b0;
        check_eq("t6_still_busy", busy1, 1'b1);
        wait_done(1'b0, 1000);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_eq("t6_done_held", done1, 1'b1);
        compare_result(1'b0);
        release_done(1'b0);

        // 6b: latency-3 core, case 1 rerun
        m_nonce = 32'h150; m_hash = 24'h0A05FF;
        launch(32'h100, 32'h1FF, 8'h10, 1'b1, 1'b1);
        wait_done(1'b1, 1000);
        compare_result(1'b1);
        release_done(1'b1);

        // 6c: reset during DRAIN of the latency-3 DUT
        m_en = 1'b0;
        launch(32'h20, 32'h22, 8'h10, 1'b1, 1'b0);
        repeat (3) tick();
        check_eq("t6_in_drain", busy3, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("t6_rst_busy",   busy3,   1'b0);
        check_eq("t6_rst_active", act3,    1'b0);
        check_eq("t6_rst_att",    att3,    32'h0);
        check_eq("t6_rst_bloque", bloque3, 128'h0);
        check_eq("t6_rst_hash",   hout3,   24'hFFFFFF);
        repeat (10) tick();
        check_eq("t6_rst_nodone", done3,   1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
